// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, FSM encoding and defaults for the writeback arbiter
package wb_pkg;
  localparam int REG_ADDR_W           = 5;
  localparam int NUM_REGS             = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic {
    NORMAL   = 1'b0,
    MEM_PRIO = 1'b1
  } wb_state_t;
endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-load bits with set/clear and the two decode busy lookups
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // x0 is never marked, so a lookup of register 0 always reads idle
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid && set_idx != '0) set_mask[set_idx] = 1'b1;
    if (clr_valid)                  clr_mask[clr_idx] = 1'b1;
  end

  // A new dispatch to the same register outranks the returning load
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - ALU/LSU writeback merge with starvation guard; WB_FORWARD_EN adds bypass outputs
module regfile_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int bitwidth     = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [bitwidth-1:0]   alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [bitwidth-1:0]   mem_data,
  output logic                  mem_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef WB_FORWARD_EN
  output logic                  rs1_fwd_valid,
  output logic [bitwidth-1:0]   rs1_fwd_data,
  output logic                  rs2_fwd_valid,
  output logic [bitwidth-1:0]   rs2_fwd_data,
`endif
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [bitwidth-1:0]   write_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_state_t  state;
  logic [3:0] starve_cnt;
  logic [3:0] cnt_inc;
  logic       alu_acc;
  logic       mem_acc;

  assign cnt_inc = starve_cnt + 4'd1;

  always_comb begin
    mem_ready = 1'b0;
    alu_stall = 1'b0;
    alu_acc   = 1'b0;
    if (!rst) begin
      if (state == MEM_PRIO) begin
        mem_ready = 1'b1;
        alu_stall = alu_valid;
      end else begin
        mem_ready = mem_valid & ~alu_valid;
        alu_acc   = alu_valid;
      end
    end
  end

  assign mem_acc = mem_valid & mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= NORMAL;
      starve_cnt   <= '0;
      write_enable <= 1'b0;
      rd           <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= 1'b0;
      // Results addressed to x0 are consumed without a write
      if (mem_acc && mem_rd != '0) begin
        write_enable <= 1'b1;
        rd           <= mem_rd;
        write_data   <= mem_data;
      end else if (alu_acc && alu_rd != '0) begin
        write_enable <= 1'b1;
        rd           <= alu_rd;
        write_data   <= alu_data;
      end

      case (state)
        NORMAL: begin
          if (mem_acc) begin
            starve_cnt <= '0;
          end else if (alu_valid && mem_valid) begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == LIMIT) state <= MEM_PRIO;
          end
        end
        // One forced slot only; an absent load simply forfeits it
        MEM_PRIO: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
        default: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
      endcase
    end
  end

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_idx   (issue_rd),
    .clr_valid (mem_acc),
    .clr_idx   (mem_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

`ifdef WB_FORWARD_EN
  assign rs1_fwd_valid = write_enable && (rd == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = write_enable && (rd == rs2) && (rs2 != '0);
  assign rs1_fwd_data  = write_data;
  assign rs2_fwd_data  = write_data;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb/tb_regfile_writeback_arbiter.sv - vector table, corner sequences and random reference-model check
module tb_regfile_writeback_arbiter;
  localparam int BW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid;
  logic [4:0]    alu_rd, mem_rd, issue_rd, rs1, rs2;
  logic [BW-1:0] alu_data, mem_data;
  logic          alu_stall, mem_ready, rs1_busy, rs2_busy, write_enable;
  logic [4:0]    rd;
  logic [BW-1:0] write_data;
`ifdef WB_FORWARD_EN
  logic          rs1_fwd_valid, rs2_fwd_valid;
  logic [BW-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.bitwidth(BW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WB_FORWARD_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
`endif
    .write_enable(write_enable), .rd(rd), .write_data(write_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic mv; logic [4:0] mrd; logic [31:0] md;
    logic iv; logic [4:0] ird;
    logic [4:0] r1; logic [4:0] r2;
    logic e_mr; logic e_st; logic e_b1; logic e_b2;
    logic e_we; logic [4:0] e_rd; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[16];

  // Behavioural reference: loss count, pending flags, last expected write
  int          losses;
  bit          pend[32];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          last_alu_acc, last_mem_acc;

  task automatic model_reset();
    losses = 0;
    foreach (pend[i]) pend[i] = 0;
    m_we = 0; m_rd = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit e_mr, e_st, a_acc, m_acc;
    #2;
    if (rst) begin
      e_mr = 0; e_st = 0; a_acc = 0; m_acc = 0;
    end else if (losses >= SL) begin
      e_mr = 1; e_st = alu_valid; a_acc = 0; m_acc = mem_valid;
    end else begin
      e_mr = mem_valid && !alu_valid; e_st = 0; a_acc = alu_valid; m_acc = e_mr;
    end
    chk("rnd_mem_ready", mem_ready, e_mr);
    chk("rnd_alu_stall", alu_stall, e_st);
    chk("rnd_rs1_busy", rs1_busy, (rs1 != 0) && pend[rs1]);
    chk("rnd_rs2_busy", rs2_busy, (rs2 != 0) && pend[rs2]);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (losses >= SL || m_acc) losses = 0;
      else if (alu_valid && mem_valid) losses++;
      m_we = 0;
      if (m_acc && mem_rd != 0) begin m_we = 1; m_rd = mem_rd; m_data = mem_data; end
      else if (a_acc && alu_rd != 0) begin m_we = 1; m_rd = alu_rd; m_data = alu_data; end
      if (m_acc) pend[mem_rd] = 0;
      if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
    end
    last_alu_acc = a_acc;
    last_mem_acc = m_acc;
    #1;
    chk("rnd_write_enable", write_enable, m_we);
    if (m_we) begin
      chk("rnd_rd", rd, m_rd);
      chk("rnd_write_data", write_data, m_data);
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();

    vecs[0]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF};
    vecs[1]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd5,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[2]  = '{1'b0,5'd0,32'h0, 1'b1,5'd0,32'h1234, 1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[3]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7, 5'd7,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[4]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd7, 1'b0,1'b0,1'b1,1'b1, 1'b0,5'd0,32'h0};
    vecs[5]  = '{1'b0,5'd0,32'h0, 1'b1,5'd7,32'h77, 1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd7,32'h77};
    vecs[6]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[7]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd7, 5'd7,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[8]  = '{1'b0,5'd0,32'h0, 1'b1,5'd7,32'h88, 1'b1,5'd7, 5'd7,5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd7,32'h88};
    vecs[9]  = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0};
    vecs[10] = '{1'b1,5'd7,32'h55, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b1,1'b0, 1'b1,5'd7,32'h55};
    vecs[11] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0};
    vecs[12] = '{1'b0,5'd0,32'h0, 1'b1,5'd7,32'h99, 1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd7,32'h99};
    vecs[13] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b1,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[14] = '{1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd7, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};
    vecs[15] = '{1'b1,5'd0,32'hFF, 1'b0,5'd0,32'h0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0};

    // Reset held two cycles with both sources requesting
    #1;
    alu_valid = 1; alu_rd = 5'd9;  alu_data = 32'h11;
    mem_valid = 1; mem_rd = 5'd10; mem_data = 32'h22;
    rs1 = 5'd10; rs2 = 5'd9;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("rst_mem_ready", mem_ready, 1'b0);
      chk("rst_alu_stall", alu_stall, 1'b0);
      if (c == 1) begin
        chk("rst_rs1_busy", rs1_busy, 1'b0);
        chk("rst_rs2_busy", rs2_busy, 1'b0);
      end
      tick();
      chk("rst_write_enable", write_enable, 1'b0);
      chk("rst_rd", rd, 5'd0);
      chk("rst_write_data", write_data, 32'h0);
    end
    rst = 0;
    #2;
    chk("post_rst_mem_ready", mem_ready, 1'b0);
    tick();
    chk("post_rst_we", write_enable, 1'b1);
    chk("post_rst_rd", rd, 5'd9);
    chk("post_rst_data", write_data, 32'h11);
    alu_valid = 0;
    #2;
    chk("post_rst_mem_ready2", mem_ready, 1'b1);
    tick();
    chk("post_rst_mem_rd", rd, 5'd10);
    idle_inputs();

    for (int i = 0; i < 16; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      rs1 = vecs[i].r1; rs2 = vecs[i].r2;
      #2;
      chk($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
      chk($sformatf("vec%0d_alu_stall", i), alu_stall, vecs[i].e_st);
      chk($sformatf("vec%0d_rs1_busy", i), rs1_busy, vecs[i].e_b1);
      chk($sformatf("vec%0d_rs2_busy", i), rs2_busy, vecs[i].e_b2);
      tick();
      chk($sformatf("vec%0d_we", i), write_enable, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_rd", i), rd, vecs[i].e_rd);
        chk($sformatf("vec%0d_data", i), write_data, vecs[i].e_data);
      end
    end

    // Continuous contention: four ALU wins then one forced load, twice
    do_reset();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1111;
    mem_valid = 1; mem_rd = 5'd2; mem_data = 32'h2222;
    for (int k = 0; k < 10; k++) begin
      #2;
      chk($sformatf("starve%0d_mem_ready", k), mem_ready, (k == 4 || k == 9));
      chk($sformatf("starve%0d_alu_stall", k), alu_stall, (k == 4 || k == 9));
      tick();
      chk($sformatf("starve%0d_we", k), write_enable, 1'b1);
      chk($sformatf("starve%0d_rd", k), rd, (k == 4 || k == 9) ? 5'd2 : 5'd1);
    end

`ifdef WB_FORWARD_EN
    do_reset();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA5;
    tick();
    alu_valid = 0; rs2 = 5'd3; rs1 = 5'd0;
    #1;
    chk("fwd_rs2_valid", rs2_fwd_valid, 1'b1);
    chk("fwd_rs2_data", rs2_fwd_data, 32'hA5);
    chk("fwd_rs1_valid", rs1_fwd_valid, 1'b0);
    rs2 = 5'd0;
    #1;
    chk("fwd_rs2_zero", rs2_fwd_valid, 1'b0);
`endif

    // Random traffic obeying the hold-until-accepted rules
    do_reset();
    model_reset();
    last_alu_acc = 1; last_mem_acc = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!(alu_valid && !last_alu_acc)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(mem_valid && !last_mem_acc)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      model_step();
      if (rst) begin
        rst = 0;
        last_alu_acc = 1; last_mem_acc = 1;
        alu_valid = 0; mem_valid = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
